// File: rtl/uart_program_loader.sv
// Boot loader: 8N1 UART receiver feeding a little-endian word assembler and a
// header/data/done FSM that writes the image into program memory, then releases the core.
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT     = 868,
  parameter int unsigned ADDRESS_BITWIDTH = 14
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        uart_rxd,
  output logic                        pm_wren,
  output logic [ADDRESS_BITWIDTH-1:0] pm_address,
  output logic [31:0]                 pm_write_data,
  output logic                        load_done,
  output logic                        cpu_reset_n,
  output logic                        frame_error
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned WIDX_W = ADDRESS_BITWIDTH - 2;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]      CAPACITY = 32'(2 ** WIDX_W);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;
  typedef enum logic [1:0] {LD_HEADER, LD_DATA, LD_LAST, LD_DONE} ld_state_e;

  logic             r_rxd_meta, r_rxd_sync;
  rx_state_e        r_rx_state, w_rx_next;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             w_cnt_clear, w_sample_bit, w_byte_good, w_byte_bad;

  ld_state_e        r_ld_state, w_ld_next;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_word;
  logic [31:0]      r_word_count, r_word_idx;
  logic [31:0]      w_word;
  logic             w_ld_active, w_word_done, w_last, w_pm_write, w_ferr_set;

  // Two-flop synchronizer, preset to the idle level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rx_state <= RX_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:      if (!r_rxd_sync) w_rx_next = RX_START;
      RX_START:     if (r_clk_cnt == HALF_M1) w_rx_next = r_rxd_sync ? RX_IDLE : RX_DATA;
      RX_DATA:      if (r_clk_cnt == FULL_M1 && r_bit_cnt == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:      if (r_clk_cnt == FULL_M1) w_rx_next = r_rxd_sync ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (r_rxd_sync) w_rx_next = RX_IDLE;
      default:      w_rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_sample_bit = 1'b0;
    w_byte_good  = 1'b0;
    w_byte_bad   = 1'b0;
    if (r_rx_state == RX_DATA && r_clk_cnt == FULL_M1) w_sample_bit = 1'b1;
    if (r_rx_state == RX_STOP && r_clk_cnt == FULL_M1) begin
      w_byte_good = r_rxd_sync;
      w_byte_bad  = !r_rxd_sync;
    end
    w_cnt_clear = (w_rx_next != r_rx_state) || w_sample_bit;
  end

  // Bit timing counter, bit counter and LSB-first shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_clk_cnt    <= w_cnt_clear ? '0 : r_clk_cnt + CNT_W'(1);
      r_byte_valid <= w_byte_good;
      if (r_rx_state == RX_START) r_bit_cnt <= '0;
      else if (w_sample_bit)      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_sample_bit) r_shift <= {r_rxd_sync, r_shift[7:1]};
    end
  end

  assign w_ld_active = r_byte_valid && (r_ld_state == LD_HEADER || r_ld_state == LD_DATA);
  assign w_word_done = w_ld_active && (r_byte_idx == 2'd3);
  assign w_word      = {r_shift, r_word};
  assign w_last      = (r_word_idx + 32'd1) == r_word_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ld_state <= LD_HEADER;
    else          r_ld_state <= w_ld_next;
  end

  always_comb begin
    w_ld_next = r_ld_state;
    case (r_ld_state)
      LD_HEADER: if (w_word_done) w_ld_next = (w_word == 32'd0) ? LD_DONE : LD_DATA;
      LD_DATA:   if (w_word_done && w_last) w_ld_next = LD_LAST;
      LD_LAST:   w_ld_next = LD_DONE;
      default:   w_ld_next = LD_DONE;
    endcase
  end

  always_comb begin
    w_pm_write = (r_ld_state == LD_DATA) && w_word_done && (r_word_idx < CAPACITY);
    w_ferr_set = w_byte_bad && (r_ld_state == LD_HEADER || r_ld_state == LD_DATA);
  end

  // Word assembly, counters and registered memory/handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_idx    <= '0;
      r_word        <= '0;
      r_word_count  <= '0;
      r_word_idx    <= '0;
      pm_wren       <= 1'b0;
      pm_address    <= '0;
      pm_write_data <= '0;
      load_done     <= 1'b0;
      cpu_reset_n   <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      if (w_ld_active) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        case (r_byte_idx)
          2'd0:    r_word[7:0]   <= r_shift;
          2'd1:    r_word[15:8]  <= r_shift;
          2'd2:    r_word[23:16] <= r_shift;
          default: ;
        endcase
      end
      if (r_ld_state == LD_HEADER && w_word_done) begin
        r_word_count <= w_word;
        r_word_idx   <= '0;
      end
      if (r_ld_state == LD_DATA && w_word_done) r_word_idx <= r_word_idx + 32'd1;
      pm_wren <= w_pm_write;
      if (w_pm_write) begin
        pm_address    <= {r_word_idx[WIDX_W-1:0], 2'b00};
        pm_write_data <= w_word;
      end
      load_done   <= (w_ld_next == LD_DONE);
      cpu_reset_n <= (w_ld_next == LD_DONE);
      frame_error <= frame_error | w_ferr_set;
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: images are modelled as lists of
// expected memory writes; a negedge monitor checks every write and the done timing.
module tb_uart_program_loader;
  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 6;
  localparam int unsigned CAP = 16;
  // start bit drive -> pm_wren / zero-header load_done: 2 sync + 1 detect + CPB/2 + 9*CPB + 1
  localparam int unsigned LAT_WREN = 3 + CPB / 2 + 9 * CPB + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          uart_rxd = 1'b1;
  logic          pm_wren;
  logic [AW-1:0] pm_address;
  logic [31:0]   pm_write_data;
  logic          load_done;
  logic          cpu_reset_n;
  logic          frame_error;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_exp;
  logic [31:0] img[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_byte_cyc = 0;
  int          last_wren_cyc = -1;
  int          done_cyc = -1;
  logic        prev_done = 1'b0;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDRESS_BITWIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rxd(uart_rxd),
    .pm_wren(pm_wren), .pm_address(pm_address), .pm_write_data(pm_write_data),
    .load_done(load_done), .cpu_reset_n(cpu_reset_n), .frame_error(frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (reset_n) begin
      if (cpu_reset_n !== load_done) begin
        fails++;
        $display("FAIL cpu_reset_n_tracks_done: cpu_reset_n=%b load_done=%b", cpu_reset_n, load_done);
      end
      if (pm_wren === 1'b1) begin
        last_wren_cyc = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: addr=%h data=%h, required no write", pm_address, pm_write_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (pm_address !== mon_exp.addr || pm_write_data !== mon_exp.data) begin
            fails++;
            $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                     pm_address, pm_write_data, mon_exp.addr, mon_exp.data);
          end
        end
      end
      if (load_done === 1'b1 && !prev_done) done_cyc = cyc;
      if (prev_done && load_done !== 1'b1) begin
        fails++;
        $display("FAIL load_done_sticky: load_done=%b, required 1", load_done);
      end
      prev_done = (load_done === 1'b1);
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_byte_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    if (!stop) send_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_pm_wren", 32'(pm_wren), 32'd0);
    check("rst_pm_address", 32'(pm_address), 32'd0);
    check("rst_pm_write_data", pm_write_data, 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    exp_q.delete();
    uart_rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    done_cyc = -1;
    last_wren_cyc = -1;
    idle(2);
  endtask

  task automatic wait_done(input logic [31:0] n);
    wr_t e;
    int  k;
    k = 0;
    while (done_cyc < 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (done_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL load_done_timeout: load_done=%b, required 1", load_done);
    end else begin
      check("load_done_latency", 32'(done_cyc - last_byte_cyc),
            (n == 0) ? 32'(LAT_WREN) : 32'(LAT_WREN + 1));
      if (n != 0 && n <= CAP)
        check("last_wren_latency", 32'(last_wren_cyc - last_byte_cyc), 32'(LAT_WREN));
    end
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    check("cpu_reset_n_released", 32'(cpu_reset_n), 32'd1);
  endtask

  // Reference model: word i of the image is written to byte address 4*i if it fits
  task automatic run_load(input logic [31:0] n);
    wr_t e;
    for (int i = 0; i < img.size(); i++) begin
      if (i < CAP) begin
        e.addr = AW'(i * 4);
        e.data = img[i];
        exp_q.push_back(e);
      end
    end
    done_cyc = -1;
    send_word(n);
    for (int i = 0; i < img.size(); i++) send_word(img[i]);
    wait_done(n);
  endtask

  initial begin
    int unsigned n;
    do_reset();

    img = '{32'h0000_0013, 32'h0050_00B3};
    run_load(32'd2);

    do_reset();
    img.delete();
    run_load(32'd0);
    send_word($urandom);
    send_byte(8'h55, 1'b0);
    idle(4 * CPB);
    check("done_ignores_frame_err", 32'(frame_error), 32'd0);
    check("done_ignores_bytes", 32'(exp_q.size()), 32'd0);

    do_reset();
    uart_rxd = 1'b0;
    @(posedge clk);
    #1;
    idle(4 * CPB);
    img = '{32'hDEAD_BEEF};
    run_load(32'd1);

    do_reset();
    img = '{32'hDEAD_BEEF};
    exp_q.push_back('{addr: AW'(0), data: 32'hDEAD_BEEF});
    img.delete();
    done_cyc = -1;
    send_word(32'd1);
    send_byte(8'hEF, 1'b0);
    check("frame_error_set", 32'(frame_error), 32'd1);
    send_word(32'hDEAD_BEEF);
    wait_done(32'd1);
    idle(2 * CPB);
    check("frame_error_sticky", 32'(frame_error), 32'd1);

    do_reset();
    img.delete();
    for (int i = 0; i < 18; i++) img.push_back(32'(i));
    run_load(32'd18);

    do_reset();
    img = '{$urandom, $urandom};
    exp_q.push_back('{addr: AW'(0), data: img[0]});
    send_word(32'd2);
    send_word(img[0]);
    send_byte(img[1][7:0], 1'b1);
    send_byte(img[1][15:8], 1'b1);
    check("midload_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("midload_load_done", 32'(load_done), 32'd0);
    do_reset();
    run_load(32'd2);

    for (int r = 0; r < 5; r++) begin
      do_reset();
      n = $urandom_range(1, 20);
      img.delete();
      for (int i = 0; i < int'(n); i++) img.push_back($urandom);
      run_load(32'(n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
